// File: rtl/pc_next_unit_pkg.sv
// Shared types and default constants for the next-PC unit and its priority selector.
package pc_next_unit_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } state_t;

  localparam int          DEF_ADDR_W      = 64;
  localparam int          DEF_NUM_SRC     = 2;
  localparam int          DEF_INSTR_BYTES = 4;
  localparam logic [63:0] DEF_RESET_PC    = 64'h0;

  // Index width for a channel count, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pc_next_unit_prio_sel.sv
// pc_prio_sel: combinational lowest-index-wins redirect selector.
// Latency 0 cycles; no backpressure, the caller decides what to do with the winner.
module pc_prio_sel
  import pc_next_unit_pkg::*;
#(
  parameter int NUM_SRC = DEF_NUM_SRC,
  parameter int ADDR_W  = DEF_ADDR_W
) (
  input  logic [NUM_SRC-1:0]               redir_valid,
  input  logic [NUM_SRC*ADDR_W-1:0]        redir_target,
  output logic                             sel_vld,
  output logic [idx_width(NUM_SRC)-1:0]    sel_idx,
  output logic [ADDR_W-1:0]                sel_dat
);

  localparam int IDX_W = idx_width(NUM_SRC);

  // Walk from the top so the lowest asserted index is the last writer.
  always_comb begin
    sel_vld = 1'b0;
    sel_idx = '0;
    sel_dat = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (redir_valid[i]) begin
        sel_vld = 1'b1;
        sel_idx = IDX_W'(i);
        sel_dat = redir_target[i*ADDR_W +: ADDR_W];
      end
    end
  end

endmodule

// File: rtl/pc_next_unit.sv
// Next-PC generator: sequential fetch with prioritised redirects; ALIGN_CHECK_EN rejects misaligned targets.
// Latency 1 cycle; pc_ready low holds pc, and a redirect seen while stalled parks in PEND.
module pc_next_unit
  import pc_next_unit_pkg::*;
#(
  parameter int                ADDR_W      = DEF_ADDR_W,
  parameter int                NUM_SRC     = DEF_NUM_SRC,
  parameter int                INSTR_BYTES = DEF_INSTR_BYTES,
  parameter logic [ADDR_W-1:0] RESET_PC    = ADDR_W'(DEF_RESET_PC)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_SRC-1:0]        redir_valid,
  input  logic [NUM_SRC*ADDR_W-1:0] redir_target,
  input  logic                      pc_ready,
  output logic [ADDR_W-1:0]         pc,
  output logic                      pc_valid,
  output logic                      flush
`ifdef ALIGN_CHECK_EN
  ,
  output logic                      align_err
`endif
);

  localparam int                IDX_W    = idx_width(NUM_SRC);
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(INSTR_BYTES - 1);
  localparam logic [ADDR_W-1:0] PC_INC   = ADDR_W'(INSTR_BYTES);

  state_t             state, state_nxt;
  logic [ADDR_W-1:0]  pc_nxt;
  logic [ADDR_W-1:0]  pend_dat, pend_dat_nxt;
  logic [IDX_W-1:0]   pend_idx, pend_idx_nxt;
  logic               flush_nxt;
  logic               align_nxt;
  logic [ADDR_W-1:0]  release_dat;

  logic               sel_vld;
  logic [IDX_W-1:0]   sel_idx;
  logic [ADDR_W-1:0]  sel_dat;
  logic [ADDR_W-1:0]  win_dat;
  logic               win_reject;

  pc_prio_sel #(
    .NUM_SRC (NUM_SRC),
    .ADDR_W  (ADDR_W)
  ) u_prio_sel (
    .redir_valid  (redir_valid),
    .redir_target (redir_target),
    .sel_vld      (sel_vld),
    .sel_idx      (sel_idx),
    .sel_dat      (sel_dat)
  );

`ifdef ALIGN_CHECK_EN
  assign win_dat    = sel_dat;
  assign win_reject = sel_vld && ((sel_dat & OFF_MASK) != '0);
`else
  // Offset bits are simply dropped so every loaded PC is instruction aligned.
  assign win_dat    = sel_dat & ~OFF_MASK;
  assign win_reject = 1'b0;
`endif

  assign pc_valid = (state == RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= BOOT;
      pc       <= RESET_PC;
      pend_dat <= '0;
      pend_idx <= '0;
      flush    <= 1'b0;
    end else begin
      state    <= state_nxt;
      pc       <= pc_nxt;
      pend_dat <= pend_dat_nxt;
      pend_idx <= pend_idx_nxt;
      flush    <= flush_nxt;
    end
  end

`ifdef ALIGN_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      align_err <= 1'b0;
    end else begin
      align_err <= align_nxt;
    end
  end
`endif

  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    pend_dat_nxt = pend_dat;
    pend_idx_nxt = pend_idx;
    flush_nxt    = 1'b0;
    align_nxt    = 1'b0;
    release_dat  = pend_dat;

    unique case (state)
      BOOT: begin
        state_nxt = RUN;
      end

      RUN: begin
        if (win_reject) begin
          align_nxt = 1'b1;
        end else if (sel_vld) begin
          flush_nxt = 1'b1;
          if (pc_ready) begin
            pc_nxt = win_dat;
          end else begin
            pend_dat_nxt = win_dat;
            pend_idx_nxt = sel_idx;
            state_nxt    = PEND;
          end
        end else if (pc_ready) begin
          pc_nxt = pc + PC_INC;
        end
      end

      PEND: begin
        if (win_reject) begin
          align_nxt = 1'b1;
        end else begin
          // Equal index replaces too: the newest redirect from a channel supersedes its older one.
          if (sel_vld && (sel_idx <= pend_idx)) begin
            pend_dat_nxt = win_dat;
            pend_idx_nxt = sel_idx;
            release_dat  = win_dat;
            flush_nxt    = 1'b1;
          end
          if (pc_ready) begin
            pc_nxt    = release_dat;
            state_nxt = RUN;
          end
        end
      end

      default: begin
        state_nxt = BOOT;
      end
    endcase
  end

endmodule

// File: tb/tb_pc_next_unit.sv
// Self-checking bench for pc_next_unit: directed scenarios plus a randomized run against a reference model.
module tb_pc_next_unit;

  localparam int          ADDR_W      = 64;
  localparam int          NUM_SRC     = 2;
  localparam int          INSTR_BYTES = 4;
  localparam logic [63:0] RESET_PC    = 64'h0;

  logic                      clk = 1'b0;
  logic                      rst_n = 1'b0;
  logic [NUM_SRC-1:0]        redir_valid = '0;
  logic [NUM_SRC*ADDR_W-1:0] redir_target = '0;
  logic                      pc_ready = 1'b0;
  logic [ADDR_W-1:0]         pc;
  logic                      pc_valid;
  logic                      flush;
`ifdef ALIGN_CHECK_EN
  logic                      align_err;
`endif

  int errors = 0;
  int checks = 0;

  pc_next_unit #(
    .ADDR_W      (ADDR_W),
    .NUM_SRC     (NUM_SRC),
    .INSTR_BYTES (INSTR_BYTES),
    .RESET_PC    (RESET_PC)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .redir_valid  (redir_valid),
    .redir_target (redir_target),
    .pc_ready     (pc_ready),
    .pc           (pc),
    .pc_valid     (pc_valid),
    .flush        (flush)
`ifdef ALIGN_CHECK_EN
    ,
    .align_err    (align_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_redir;
    redir_valid  = '0;
    redir_target = '0;
  endtask

  task automatic set_chan(input int ch, input logic [63:0] tgt);
    redir_valid[ch] = 1'b1;
    redir_target[ch*ADDR_W +: ADDR_W] = tgt;
  endtask

  // Leaves the DUT in RUN with pc == RESET_PC, sampled just after the BOOT edge.
  task automatic reset_run;
    clear_redir();
    pc_ready = 1'b0;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset;
    logic [65:0] obs, exp;
    reset_run();
    pc_ready = 1'b1;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    obs = {pc_valid, flush, pc};
    exp = {1'b0, 1'b0, RESET_PC};
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL reset_values: got %h expected %h", obs, exp);
    end
`ifdef ALIGN_CHECK_EN
    checks++;
    if (align_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_align_err: got %b expected 0", align_err);
    end
`endif
  endtask

  task automatic test_sequential;
    logic [65:0] obs, exp;
    clear_redir();
    pc_ready = 1'b1;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++;
    if (pc_valid !== 1'b0) begin
      errors++;
      $display("FAIL boot_valid: got %b expected 0", pc_valid);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      obs = {pc_valid, flush, pc};
      exp = {1'b1, 1'b0, 64'(i * 4)};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL seq_pc[%0d]: got %h expected %h", i, obs, exp);
      end
    end
  endtask

  task automatic test_redirect_prio;
    logic [65:0] obs, exp;
    reset_run();
    pc_ready = 1'b1;
    repeat (4) tick();
    checks++;
    if (pc !== 64'h10) begin
      errors++;
      $display("FAIL prio_setup_pc: got %h expected 10", pc);
    end
    set_chan(0, 64'h100);
    set_chan(1, 64'h200);
    tick();
    clear_redir();
    obs = {pc_valid, flush, pc};
    exp = {1'b1, 1'b1, 64'h100};
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL prio_redirect: got %h expected %h", obs, exp);
    end
    tick();
    obs = {pc_valid, flush, pc};
    exp = {1'b1, 1'b0, 64'h104};
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL prio_after: got %h expected %h", obs, exp);
    end
  endtask

  task automatic test_pend_replace;
    logic [65:0] obs, exp;
    int nflush = 0;
    int valid_seen = 0;
    reset_run();
    pc_ready = 1'b0;
    set_chan(1, 64'h200);
    tick();
    clear_redir();
    nflush += int'(flush);
    valid_seen += int'(pc_valid);
    tick();
    nflush += int'(flush);
    valid_seen += int'(pc_valid);
    set_chan(0, 64'h300);
    tick();
    clear_redir();
    nflush += int'(flush);
    valid_seen += int'(pc_valid);
    checks++;
    if (nflush !== 2 || valid_seen !== 0) begin
      errors++;
      $display("FAIL pend_stall: flushes %0d valid_cycles %0d expected 2 and 0", nflush, valid_seen);
    end
    pc_ready = 1'b1;
    tick();
    obs = {pc_valid, flush, pc};
    exp = {1'b1, 1'b0, 64'h300};
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL pend_release: got %h expected %h", obs, exp);
    end
  endtask

  task automatic test_pend_drop;
    logic [65:0] obs, exp;
    reset_run();
    pc_ready = 1'b0;
    set_chan(0, 64'h300);
    tick();
    clear_redir();
    set_chan(1, 64'h400);
    tick();
    clear_redir();
    obs = {pc_valid, flush, pc};
    exp = {1'b0, 1'b0, RESET_PC};
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL drop_no_flush: got %h expected %h", obs, exp);
    end
    pc_ready = 1'b1;
    tick();
    obs = {pc_valid, flush, pc};
    exp = {1'b1, 1'b0, 64'h300};
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL drop_release: got %h expected %h", obs, exp);
    end
  endtask

  task automatic test_wrap;
    logic [65:0] obs, exp;
    reset_run();
    pc_ready = 1'b1;
    set_chan(1, 64'hFFFF_FFFF_FFFF_FFFC);
    tick();
    clear_redir();
    tick();
    obs = {pc_valid, flush, pc};
    exp = {1'b1, 1'b0, 64'h0};
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL wrap: got %h expected %h", obs, exp);
    end
  endtask

  task automatic test_reset_mid_pend;
    logic [65:0] obs, exp;
    reset_run();
    pc_ready = 1'b1;
    repeat (2) tick();
    pc_ready = 1'b0;
    set_chan(1, 64'h500);
    tick();
    clear_redir();
    #2;
    rst_n = 1'b0;
    #1;
    obs = {pc_valid, flush, pc};
    exp = {1'b0, 1'b0, RESET_PC};
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL async_reset_pend: got %h expected %h", obs, exp);
    end
    pc_ready = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    obs = {pc_valid, flush, pc};
    exp = {1'b1, 1'b0, RESET_PC + 64'd4};
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL pend_cleared: got %h expected %h", obs, exp);
    end
  endtask

  task automatic test_misalign;
    logic [65:0] obs, exp;
    reset_run();
    pc_ready = 1'b1;
    set_chan(0, 64'h102);
    tick();
    clear_redir();
    obs = {pc_valid, flush, pc};
`ifdef ALIGN_CHECK_EN
    exp = {1'b1, 1'b0, RESET_PC};
    checks++;
    if (align_err !== 1'b1) begin
      errors++;
      $display("FAIL misalign_err: got %b expected 1", align_err);
    end
`else
    exp = {1'b1, 1'b1, 64'h100};
`endif
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL misalign: got %h expected %h", obs, exp);
    end
  endtask

  task automatic test_random;
    logic [63:0] m_pc, m_pend, t;
    int          m_pch, win;
    bit          m_stall, m_flush, m_aerr, rej;
    logic [65:0] obs, exp;
    reset_run();
    m_pc = RESET_PC;
    m_stall = 1'b0;
    m_pend = '0;
    m_pch = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      pc_ready = ($urandom_range(0, 9) < 7);
      clear_redir();
      for (int ch = 0; ch < NUM_SRC; ch++) begin
        if ($urandom_range(0, 3) == 0) begin
          t = {$urandom, $urandom};
          if ($urandom_range(0, 1) == 1) t[1:0] = 2'b00;
          set_chan(ch, t);
        end
      end
      win = -1;
      for (int ch = NUM_SRC - 1; ch >= 0; ch--)
        if (redir_valid[ch]) win = ch;
      t = (win >= 0) ? redir_target[win*ADDR_W +: ADDR_W] : 64'h0;
      rej = 1'b0;
      m_flush = 1'b0;
      m_aerr = 1'b0;
`ifdef ALIGN_CHECK_EN
      if (win >= 0 && (t % INSTR_BYTES) != 0) rej = 1'b1;
`else
      t = t - (t % INSTR_BYTES);
`endif
      if (rej) begin
        m_aerr = 1'b1;
      end else if (!m_stall) begin
        if (win >= 0) begin
          m_flush = 1'b1;
          if (pc_ready) m_pc = t;
          else begin
            m_stall = 1'b1;
            m_pend = t;
            m_pch = win;
          end
        end else if (pc_ready) begin
          m_pc = m_pc + INSTR_BYTES;
        end
      end else begin
        if (win >= 0 && win <= m_pch) begin
          m_pend = t;
          m_pch = win;
          m_flush = 1'b1;
        end
        if (pc_ready) begin
          m_pc = m_pend;
          m_stall = 1'b0;
        end
      end
      tick();
      obs = {pc_valid, flush, pc};
      exp = {!m_stall, m_flush, m_pc};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL random[%0d]: got %h expected %h", cyc, obs, exp);
      end
`ifdef ALIGN_CHECK_EN
      checks++;
      if (align_err !== m_aerr) begin
        errors++;
        $display("FAIL random_align[%0d]: got %b expected %b", cyc, align_err, m_aerr);
      end
`else
      if (m_aerr) m_aerr = 1'b0;
`endif
    end
    clear_redir();
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_redirect_prio();
    test_pend_replace();
    test_pend_drop();
    test_wrap();
    test_reset_mid_pend();
    test_misalign();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pc_next_unit.md
PC_NEXT_UNIT -- requirements
Module: pc_next_unit

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 64, giving the PC and target width.
REQ-002 The block SHALL have parameter NUM_SRC, default 2, giving the number of redirect channels; channel 0 has the highest priority.
REQ-003 The block SHALL have parameter INSTR_BYTES, default 4 (power of two), giving the sequential PC increment.
REQ-004 The block SHALL have parameter RESET_PC, default 0, giving the PC value loaded at reset.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port rst_n, input, 1 bit: the reset, asynchronous and active-low.
REQ-007 The block SHALL have port redir_valid, input, NUM_SRC bits: per-channel redirect request.
REQ-008 The block SHALL have port redir_target, input, NUM_SRC*ADDR_W bits: per-channel target, with channel i at bits [i*ADDR_W +: ADDR_W].
REQ-009 The block SHALL have port pc_ready, input, 1 bit: fetch stage can accept a PC.
REQ-010 The block SHALL have port pc, output, ADDR_W bits: current fetch address.
REQ-011 The block SHALL have port pc_valid, output, 1 bit: pc is valid for fetch.
REQ-012 The block SHALL have port flush, output, 1 bit: one-cycle pulse per accepted redirect.
REQ-013 The block SHALL have port align_err, output, 1 bit: one-cycle pulse per rejected misaligned redirect; it is present only with ALIGN_CHECK_EN.

Function
REQ-014 The block SHALL implement the states BOOT, RUN and PEND.
REQ-015 BOOT SHALL hold pc_valid=0 for exactly one cycle, then go to RUN.
REQ-016 In RUN, pc_valid SHALL be 1; a transfer occurs when pc_valid and pc_ready are both 1.
REQ-017 Selection SHALL take the lowest-index asserted redir_valid channel as the winner; the other channels are discarded that cycle.
REQ-018 In RUN with a winner and pc_ready=1, pc SHALL be set to the winner's target next cycle, and the state SHALL stay RUN.
REQ-019 In RUN with a winner and pc_ready=0, the block SHALL latch the target and channel index into the pending register and go to PEND; pc SHALL hold.
REQ-020 In RUN with no winner, a transfer SHALL set pc to pc+INSTR_BYTES, modulo 2^ADDR_W (wrap to 0, no error); with no transfer, pc SHALL hold.
REQ-021 flush SHALL pulse high the cycle after any redirect is accepted, whether it is applied directly or latched pending.
REQ-022 In PEND, pc_valid SHALL be 0.
REQ-023 In PEND, a new winner with index less than or equal to the pending index SHALL replace the pending entry and re-pulse flush; a lower-priority winner SHALL be dropped with no flush.
REQ-024 In PEND with pc_ready=1, pc SHALL be set to the pending target (after the REQ-023 replacement in the same cycle), and the state SHALL go to RUN.
REQ-025 A redirect SHALL never be lost while in PEND; only the REQ-023 priority rule discards one.

Reset
REQ-026 On rst_n low, the block SHALL immediately set pc=RESET_PC, pc_valid=0, flush=0, align_err=0, state=BOOT, and clear the pending register, including mid-redirect or while in PEND.
REQ-027 On reset deassertion, BOOT timing SHALL start at the first rising edge of clk.

Configuration
REQ-028 With macro ALIGN_CHECK_EN defined, a winner whose target has any of its low log2(INSTR_BYTES) bits set SHALL be rejected: pc and state unchanged, no flush, align_err pulses the next cycle, and lower-priority channels are not considered.
REQ-029 With ALIGN_CHECK_EN undefined, the align_err port SHALL be absent, and the low log2(INSTR_BYTES) bits of every target SHALL be forced to 0 on load.

Structure
REQ-030 The shared package SHALL hold the state enum (BOOT, RUN, PEND) and the default ADDR_W, INSTR_BYTES and RESET_PC constants.
REQ-031 The block SHALL contain one sub-module, pc_prio_sel: a combinational lowest-index-wins selector returning the valid flag, index and target, parametrised by NUM_SRC and ADDR_W.

Verification
REQ-032 Reset then pc_ready=1 held, no redirects -> pc_valid=0 for 1 cycle, then pc sequence 0x0, 0x4, 0x8, 0xC.
REQ-033 At pc=0x10, redir_valid=2'b11 with targets ch0=0x100 and ch1=0x200, pc_ready=1 -> next pc=0x100, flush pulse 1 cycle.
REQ-034 With pc_ready=0, a ch1 redirect to 0x200 is followed 2 cycles later by a ch0 redirect to 0x300, then pc_ready=1 -> pc_valid=0 throughout the stall, 2 flush pulses, pc=0x300, state RUN.
REQ-035 Starting in PEND with ch0 pending to 0x300, a ch1 redirect to 0x400 arrives -> dropped, no flush, pc=0x300 on release.
REQ-036 With pc=0xFFFF_FFFF_FFFF_FFFC and a transfer -> pc=0x0; rst_n asserted low mid-PEND -> pc=RESET_PC and pc_valid=0 immediately.
REQ-037 A redirect to target 0x102: with ALIGN_CHECK_EN -> align_err pulse, pc unchanged, no flush; without ALIGN_CHECK_EN -> pc=0x100 and flush pulse.
